// File: rtl/posit_64_4_encoder_if.sv
// Handshake and data bundle for the posit<64,4> encoder.
// The master drives the input fields and out_rdy; the slave (the encoder) drives in_rdy, out_vld and posit.
interface posit_64_4_encoder_if #(
   parameter int N  = 64,
   parameter int ES = 4,
   parameter int RS = 7,
   parameter int FS = N - 3 - ES
);
   logic          in_vld;
   logic          in_rdy;
   logic          sign;
   logic [RS-1:0] regi;
   logic [ES-1:0] expo;
   logic [FS-1:0] frac;
   logic          zero;
   logic          inf;
   logic          out_vld;
   logic          out_rdy;
   logic [N-1:0]  posit;

   modport master (
      output in_vld, sign, regi, expo, frac, zero, inf, out_rdy,
      input  in_rdy, out_vld, posit
   );

   modport slave (
      input  in_vld, sign, regi, expo, frac, zero, inf, out_rdy,
      output in_rdy, out_vld, posit
   );
endinterface

// File: rtl/posit_64_4_encoder.sv
// Three-stage posit<64,4> encoder: regime build, shift and round, two's complement.
// Define POSIT_ENC_RNE_EN for round-to-nearest-even; the default build truncates.
module posit_64_4_encoder #(
   parameter int N  = 64,
   parameter int ES = 4,
   parameter int RS = 7,
   parameter int FS = N - 3 - ES
) (
   input  logic                 clk,
   input  logic                 rst,
   posit_64_4_encoder_if.slave  bus
);
   localparam int BW = N - 1;
   localparam int XW = 2 * N;
   localparam int SW = RS - 1;
   localparam logic [BW-1:0] MINPOS = {{(BW-1){1'b0}}, 1'b1};

   logic          w_stall, w_adv, w_kNeg, w_satHi, w_satLo;
   logic [SW-1:0] w_shamt;
   logic          r_v1, r_sign1, r_zero1, r_inf1, r_satHi1, r_satLo1;
   logic [SW-1:0] r_shamt1;
   logic [BW-1:0] r_head1;
   logic [BW-1:0] w_body, w_bodyFinal;
   logic          w_inc;
   logic [BW:0]   w_sum;
   logic          r_v2, r_sign2, r_zero2, r_inf2;
   logic [BW-1:0] r_body2;
   logic [N-1:0]  w_word, w_posit, r_posit;
   logic          r_outVld;

   assign w_stall     = r_outVld & ~bus.out_rdy;
   assign w_adv       = ~w_stall;
   assign bus.in_rdy  = rst | w_adv;
   assign bus.out_vld = r_outVld;
   assign bus.posit   = r_posit;

   // Regime is produced by an arithmetic shift of "10" (k>=0) or "01" (k<0) by k or -k-1
   assign w_kNeg  = bus.regi[RS-1];
   assign w_shamt = w_kNeg ? ~bus.regi[SW-1:0] : bus.regi[SW-1:0];
   assign w_satHi = ~w_kNeg & (bus.regi[RS-2:0] >= (RS-1)'(N - 2));
   assign w_satLo =  w_kNeg & (bus.regi[RS-2:0] <= (RS-1)'(2**(RS-1) - (N - 1)));

`ifdef POSIT_ENC_RNE_EN
   logic [XW-1:0] w_shifted;
   logic          w_guard, w_sticky;

   assign w_shifted = $signed({r_head1, {(XW-BW){1'b0}}}) >>> r_shamt1;
   assign w_body    = w_shifted[XW-1 -: BW];
   assign w_guard   = w_shifted[XW-BW-1];
   assign w_sticky  = |w_shifted[XW-BW-2:0];
   assign w_inc     = w_guard & (w_sticky | w_body[0]);
`else
   assign w_body = $signed(r_head1) >>> r_shamt1;
   assign w_inc  = 1'b0;
`endif

   assign w_sum = {1'b0, w_body} + {{BW{1'b0}}, w_inc};

   // Saturated values bypass rounding; rounding never wraps past maxpos nor reaches zero
   always_comb begin
      w_bodyFinal = w_sum[BW-1:0];
      if (r_satHi1)
         w_bodyFinal = '1;
      else if (r_satLo1)
         w_bodyFinal = MINPOS;
      else if (w_sum[BW])
         w_bodyFinal = '1;
      else if (w_sum[BW-1:0] == '0)
         w_bodyFinal = MINPOS;
   end

   always_comb begin
      w_word  = {1'b0, r_body2};
      w_posit = r_sign2 ? (~w_word + N'(1)) : w_word;
      if (r_inf2)
         w_posit = {1'b1, {(N-1){1'b0}}};
      else if (r_zero2)
         w_posit = '0;
   end

   // All three stages move in lockstep and freeze together while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1     <= 1'b0;
         r_v2     <= 1'b0;
         r_outVld <= 1'b0;
         r_posit  <= '0;
      end else if (w_adv) begin
         r_v1     <= bus.in_vld;
         r_sign1  <= bus.sign;
         r_zero1  <= bus.zero;
         r_inf1   <= bus.inf;
         r_satHi1 <= w_satHi;
         r_satLo1 <= w_satLo;
         r_shamt1 <= w_shamt;
         r_head1  <= {~w_kNeg, w_kNeg, bus.expo, bus.frac};
         r_v2     <= r_v1;
         r_sign2  <= r_sign1;
         r_zero2  <= r_zero1;
         r_inf2   <= r_inf1;
         r_body2  <= w_bodyFinal;
         r_outVld <= r_v2;
         r_posit  <= w_posit;
      end
   end
endmodule

// File: doc/posit_64_4_encoder.md
POSIT_64_4_ENCODER -- requirements
Module: posit_64_4_encoder

Interface
REQ-001 SHALL have parameter N, default 64, posit width; ES, default 4, exponent width; RS, default 7, regime width; FS = N-3-ES, fraction width (57).
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports in_vld  input  1  input valid; in_rdy  output  1  input ready.
REQ-005 SHALL have port sign  input  1  sign of value.
REQ-006 SHALL have port regi  input  RS  regime k, two's complement, range -64..63.
REQ-007 SHALL have ports expo  input  ES  exponent; frac  input  FS  fraction, hidden bit excluded, MSB first.
REQ-008 SHALL have ports zero  input  1  value is zero; inf  input  1  value is NaR (inf dominates zero).
REQ-009 SHALL have ports out_vld  output  1  output valid; out_rdy  input  1  downstream ready.
REQ-010 SHALL have port posit  output  N  encoded posit.

Function
REQ-011 SHALL be a 3-stage pipeline: S1 regime build and saturation detect, S2 shift plus round, S3 two's-complement and output register.
REQ-012 SHALL advance all stages together when stall is 0, where stall = out_vld & ~out_rdy; in_rdy = ~stall (combinational).
REQ-013 SHALL accept an input only on in_vld & in_rdy; latency is exactly 3 clk edges from accept to out_vld with no stall; one result per cycle sustained.
REQ-014 SHALL hold posit and out_vld stable while stalled; no data dropped or duplicated.
REQ-015 SHALL build the regime field as k+1 ones then one zero for k>=0, and -k zeros then one one for k<0.
REQ-016 SHALL form body = top 63 bits of {regime, expo, frac, zeros}; guard = next bit; sticky = OR of all remaining bits.
REQ-017 SHALL saturate: k>=62 gives body 63'h7FFF_FFFF_FFFF_FFFF (maxpos); k<=-63 gives body 63'h1 (minpos); no rounding on saturated values.
REQ-018 SHALL never round a nonzero value to body 0 (clamp to minpos) nor carry past maxpos (clamp to maxpos).
REQ-019 SHALL output {1'b0, body} when sign=0 and the two's complement of {1'b0, body} when sign=1.
REQ-020 SHALL output 64'h0 for zero=1 and 64'h8000_0000_0000_0000 for inf=1, regardless of sign, regi, expo, frac.

Reset
REQ-021 SHALL on rst=1 at a clk edge clear all stage valids, out_vld=0 and posit=0; in_rdy=1 during and after reset.
REQ-022 SHALL discard in-flight data when rst is asserted mid-operation; first output after reset comes from a post-reset accept.

Configuration
REQ-023 SHALL, with POSIT_ENC_RNE_EN defined, round body to nearest, ties to even: increment if guard & (sticky | body[0]).
REQ-024 SHALL, without POSIT_ENC_RNE_EN, truncate (guard and sticky ignored), apart from the minpos clamp of REQ-018; latency is unchanged.

Verification
REQ-025 SHALL cover: sign=0, regi=0, expo=0, frac=0 -> posit 64'h4000_0000_0000_0000 exactly 3 cycles after accept; sign=1 with the same fields -> 64'hC000_0000_0000_0000.
REQ-026 SHALL cover: regi=-1 (7'h7F), expo=0, frac=0 -> 64'h2000_0000_0000_0000; zero=1 -> 64'h0; inf=1, sign=0 -> 64'h8000_0000_0000_0000.
REQ-027 SHALL cover: regi=62 -> 64'h7FFF_FFFF_FFFF_FFFF; regi=-64, sign=1 -> 64'hFFFF_FFFF_FFFF_FFFF.
REQ-028 SHALL cover: regi=59, expo=4'b0011, frac=0 -> 64'h7FFF_FFFF_FFFF_FFF9 with POSIT_ENC_RNE_EN defined, 64'h7FFF_FFFF_FFFF_FFF8 without it.
REQ-029 SHALL cover: 8 back-to-back inputs with out_rdy low for cycles 4-6 -> in_rdy low while stalled, all 8 outputs in order and unchanged across the stall.
REQ-030 SHALL cover: rst pulsed 1 cycle with 2 items in flight -> out_vld=0 the next cycle, no stale output afterwards.
